input_port6502: RTL
===================

INPUT_PORT6502 -- requirements
Module: input_port6502

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, stable-sample count before a button level change is accepted (legal range 2..65535).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 switches  input  16  raw board slide switches, asynchronous to clk.
REQ-005 buttons  input  5  raw board push buttons, asynchronous, bouncing.
REQ-006 cs  input  1  CPU bus select for this port.
REQ-007 we  input  1  1 = write, 0 = read; sampled only when cs=1.
REQ-008 addr  input  2  register select.
REQ-009 data_in  input  8  CPU write data.
REQ-010 data_out  output  8  registered CPU read data.
REQ-011 irq  output  1  level interrupt request to CPU, active-high.

Function
REQ-012 Every switches and buttons bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per button: a 16-bit counter SHALL clear when the synced input equals the debounced level, else increment; when it reaches DEBOUNCE_CYCLES-1 the debounced level SHALL take the synced value and the counter SHALL clear.
REQ-014 A debounced 0->1 transition SHALL set the matching bit of the 5-bit sticky event register.
REQ-015 Register map (read): addr 0 = synced switches[7:0]; 1 = switches[15:8]; 2 = {3'b0, debounced buttons}; 3 = {3'b0, events}.
REQ-016 Register map (write): addr 3 = irq mask[4:0] from data_in[4:0]; writes to addr 0..2 SHALL be ignored.
REQ-017 Read latency: data_out SHALL hold the addressed value on the edge after cs=1, we=0 is sampled, and SHALL hold that value until the next read.
REQ-018 A read of addr 3 SHALL clear every event bit it returned, on the same edge data_out is loaded.
REQ-019 Simultaneous read-clear of addr 3 and new press on bit k: bit k SHALL read as the pre-edge value and be left set afterwards (set wins).
REQ-020 irq SHALL be registered and equal |(events & mask), one cycle after the contributing state changes.
REQ-021 Debounced button state machine per bit: STABLE (counter 0) -> COUNTING on mismatch -> STABLE on match or on terminal count; glitch shorter than DEBOUNCE_CYCLES SHALL produce no level change and no event.
REQ-022 cs=0 cycles SHALL leave data_out, events and mask unchanged except for REQ-014 setting.

Reset
REQ-023 reset_n low SHALL asynchronously clear synchronizers, counters, debounced levels, events, mask, data_out (8'h00) and irq (0).
REQ-024 Reset asserted mid-debounce SHALL discard the count; on release, a button already held SHALL register a press after synchronizer latency plus DEBOUNCE_CYCLES.
REQ-025 Reset deassertion SHALL be glitch-free to outputs: irq stays 0 until an event and mask bit are both set.

Structure
REQ-026 Register address constants (REG_SW_LO=0, REG_SW_HI=1, REG_BTN=2, REG_EVT=3) and button/switch widths SHALL live in the shared system6502 package.
REQ-027 One sub-module, debounce_bit (synchronizer + counter + level, parameterised by DEBOUNCE_CYCLES), SHALL be instantiated 5 times.
REQ-028 Target size 120-400 lines RTL total.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 switches=16'h1234, read addr 0 then 1 (after 3 cycles) -> data_out 8'h34 then 8'h12.
REQ-030 buttons[2] held 1 for 10 cycles, read addr 2 -> 8'h04; read addr 3 -> 8'h04; read addr 3 again -> 8'h00.
REQ-031 buttons[1] pulsed 1 for 2 cycles -> addr 2 and addr 3 read 8'h00, irq stays 0.
REQ-032 Write 8'h01 to addr 3, press buttons[0] -> irq=1; read addr 3 -> 8'h01, irq=0 the cycle after.
REQ-033 Press buttons[3] timed so its event sets on the read-clear edge of addr 3 -> read returns bit3=0, next read returns 8'h08.
REQ-034 Assert reset_n=0 mid-count with buttons[4] held -> all outputs 0 immediately; after release, event bit 4 sets after 2+4 cycles.

Source files
------------

// File: rtl/system6502_pkg.sv
// Shared constants for the 6502 system peripherals: register map and board I/O widths.
package system6502_pkg;

   localparam int unsigned SW_W      = 16;
   localparam int unsigned BTN_W     = 5;
   localparam int unsigned DEB_CNT_W = 16;

   typedef logic [1:0] reg_addr_t;

   localparam reg_addr_t REG_SW_LO = 2'd0;
   localparam reg_addr_t REG_SW_HI = 2'd1;
   localparam reg_addr_t REG_BTN   = 2'd2;
   localparam reg_addr_t REG_EVT   = 2'd3;

endpackage

// File: rtl/input_port6502_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter and debounced level.
module debounce_bit
   import system6502_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam logic [DEB_CNT_W-1:0] TERM = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   logic                 r_level;
   logic [DEB_CNT_W-1:0] r_cnt;
   logic                 w_mismatch;
   logic                 w_term;

   // Counter at zero is the STABLE state; any nonzero count is COUNTING.
   assign w_mismatch = (r_sync2 != r_level);
   assign w_term     = w_mismatch && (r_cnt == TERM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_term) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   // Fires on the same edge the level goes high so the event register sets without extra delay.
   assign o_rise  = w_term && r_sync2;

endmodule

// File: rtl/input_port6502.sv
// CPU-visible input port: synchronized switches, debounced buttons, sticky press events and masked IRQ.
module input_port6502
   import system6502_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [SW_W-1:0]  switches,
   input  logic [BTN_W-1:0] buttons,
   input  logic             cs,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [7:0]       data_in,
   output logic [7:0]       data_out,
   output logic             irq
);

   logic [SW_W-1:0]  r_sw_sync1;
   logic [SW_W-1:0]  r_sw_sync2;
   logic [BTN_W-1:0] r_events;
   logic [BTN_W-1:0] r_mask;
   logic [7:0]       r_data_out;
   logic             r_irq;

   logic [BTN_W-1:0] w_btn_level;
   logic [BTN_W-1:0] w_btn_rise;
   logic [BTN_W-1:0] w_evt_clr;
   logic [7:0]       w_rd_data;
   logic             w_rd;
   logic             w_wr;
   logic             w_unused;

   for (genvar g = 0; g < BTN_W; g++) begin : g_btn
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk     (clk),
         .reset_n (reset_n),
         .i_raw   (buttons[g]),
         .o_level (w_btn_level[g]),
         .o_rise  (w_btn_rise[g])
      );
   end

   assign w_rd     = cs && !we;
   assign w_wr     = cs && we;
   assign w_unused = &{1'b0, data_in[7:BTN_W]};

   always_comb begin
      w_rd_data = '0;
      case (addr)
         REG_SW_LO: w_rd_data = r_sw_sync2[7:0];
         REG_SW_HI: w_rd_data = r_sw_sync2[15:8];
         REG_BTN:   w_rd_data = {3'b000, w_btn_level};
         default:   w_rd_data = {3'b000, r_events};
      endcase
   end

   // Only bits actually returned by the read are cleared; a press on the same edge is ORed back in.
   assign w_evt_clr = (w_rd && (addr == REG_EVT)) ? r_events : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sw_sync1 <= '0;
         r_sw_sync2 <= '0;
         r_events   <= '0;
         r_mask     <= '0;
         r_data_out <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_sw_sync1 <= switches;
         r_sw_sync2 <= r_sw_sync1;
         r_events   <= (r_events & ~w_evt_clr) | w_btn_rise;
         r_irq      <= |(r_events & r_mask);
         if (w_rd) begin
            r_data_out <= w_rd_data;
         end
         if (w_wr && (addr == REG_EVT)) begin
            r_mask <= data_in[BTN_W-1:0];
         end
      end
   end

   assign data_out = r_data_out;
   assign irq      = r_irq;

endmodule
